// File: rtl/y_adder_pkg.sv
// ============================================================================
// Module   : y_adder_pkg
// Brief    : Shared constants for the y_adder ripple-carry adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package y_adder_pkg;

    localparam int unsigned c_Y_ADDER_WIDTH = 32;

endpackage : y_adder_pkg

`default_nettype wire

// File: rtl/y_adder1.sv
// ============================================================================
// Module   : y_adder1
// Brief    : One-bit full adder cell used to build the ripple-carry chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module y_adder1 (
    output logic z,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    logic w_p;

    assign w_p  = a ^ b;
    assign z    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule : y_adder1

`default_nettype wire

// File: rtl/y_adder.sv
// ============================================================================
// Module   : y_adder
// Brief    : Ripple-carry adder with combinational sum/carry and registered
//            sum, carry and two's-complement overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module y_adder
    import y_adder_pkg::*;
#(
    parameter int unsigned WIDTH = c_Y_ADDER_WIDTH
) (
    output logic [WIDTH-1:0] z,
    output logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] z_q,
    output logic             cout_q,
    output logic             ovf_q
);

    logic w_msb_cin;
    logic w_ovf;

    // Each cell keeps its own carry nets so the chain is not one self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_ci;
        logic w_co;

        if (i == 0) begin : g_first
            assign w_ci = cin;
        end else begin : g_chain
            assign w_ci = g_bit[i-1].w_co;
        end

        y_adder1 u_cell (
            .z    (z[i]),
            .cout (w_co),
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_ci)
        );
    end

    assign cout      = g_bit[WIDTH-1].w_co;
    assign w_msb_cin = g_bit[WIDTH-1].w_ci;
    assign w_ovf     = w_msb_cin ^ cout;

    always_ff @(posedge clk) begin
        if (reset) begin
            z_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            z_q    <= z;
            cout_q <= cout;
            ovf_q  <= w_ovf;
        end
    end

endmodule : y_adder

`default_nettype wire

// File: tb/tb_y_adder.sv
// ============================================================================
// Module   : tb_y_adder
// Brief    : Self-checking bench for y_adder against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_y_adder;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] z;
    logic             cout;
    logic [WIDTH-1:0] z_q;
    logic             cout_q;
    logic             ovf_q;

    int passed;
    int total;

    y_adder #(.WIDTH(WIDTH)) dut (
        .z      (z),
        .cout   (cout),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .clk    (clk),
        .reset  (reset),
        .z_q    (z_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned sum at WIDTH+1 bits; overflow when equal-signed operands give a differently-signed result.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic             mcin);
        logic [WIDTH:0] sum;
        logic           ovf;
        sum = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mcin};
        ovf = (ma[WIDTH-1] == mb[WIDTH-1]) && (sum[WIDTH-1] != ma[WIDTH-1]);
        return {ovf, sum};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        a = $urandom; b = $urandom; cin = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({z_q, cout_q, ovf_q} !== {{WIDTH{1'b0}}, 2'b00})
            $display("FAIL reset_state got z_q=%h cout_q=%b ovf_q=%b exp 0/0/0", z_q, cout_q, ovf_q);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_random_comb();
        int errs = 0;
        logic [WIDTH+1:0] e;
        for (int i = 0; i < 500; i++) begin
            a = $urandom; b = $urandom; cin = 1'b0;
            #1;
            e = model(a, b, cin);
            if ({cout, z} !== e[WIDTH:0]) begin
                errs++;
                $display("FAIL random_sum[%0d] a=%h b=%h got %b_%h exp %b_%h",
                         i, a, b, cout, z, e[WIDTH], e[WIDTH-1:0]);
            end
        end
        total++;
        if (errs == 0) passed++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH+1:0] e;
        logic [WIDTH+1:0] e_reg;
        int errs = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 60; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
            if (i % 7 == 0) b = ~a;
            if (i % 11 == 0) begin a = {1'b0, {(WIDTH-1){1'b1}}}; b = $urandom_range(0, 3); end
            #1;
            e = model(a, b, cin);
            if ({cout, z} !== e[WIDTH:0]) begin
                errs++;
                $display("FAIL b2b_comb[%0d] got %b_%h exp %b_%h", i, cout, z, e[WIDTH], e[WIDTH-1:0]);
            end
            e_reg = e;
            @(posedge clk); #1;
            if ({ovf_q, cout_q, z_q} !== e_reg) begin
                errs++;
                $display("FAIL b2b_reg[%0d] got ovf=%b c=%b z=%h exp ovf=%b c=%b z=%h", i,
                         ovf_q, cout_q, z_q, e_reg[WIDTH+1], e_reg[WIDTH], e_reg[WIDTH-1:0]);
            end
        end
        total++;
        if (errs == 0) passed++;
    endtask

    task automatic test_carry_wrap();
        a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1;
        #1;
        total++;
        if ({cout, z} !== {1'b1, 32'h0})
            $display("FAIL wrap_comb got %b_%h exp 1_00000000", cout, z);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({ovf_q, cout_q, z_q} !== {2'b01, 32'h0})
            $display("FAIL wrap_reg got ovf=%b c=%b z=%h exp 0/1/00000000", ovf_q, cout_q, z_q);
        else passed++;
    endtask

    task automatic test_signed_overflow();
        a = 32'h7FFF_FFFF; b = 32'h1; cin = 1'b0;
        #1;
        total++;
        if ({cout, z} !== {1'b0, 32'h8000_0000})
            $display("FAIL ovf_comb got %b_%h exp 0_80000000", cout, z);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({ovf_q, cout_q, z_q} !== {2'b10, 32'h8000_0000})
            $display("FAIL ovf_reg got ovf=%b c=%b z=%h exp 1/0/80000000", ovf_q, cout_q, z_q);
        else passed++;
        // Negative overflow: min + min
        a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({ovf_q, cout_q, z_q} !== {2'b11, 32'h0})
            $display("FAIL ovf_neg_reg got ovf=%b c=%b z=%h exp 1/1/00000000", ovf_q, cout_q, z_q);
        else passed++;
    endtask

    task automatic test_carry_cin();
        a = 32'h1234_5678; b = 32'h8765_4321; cin = 1'b1;
        #1;
        total++;
        if ({cout, z} !== {1'b0, 32'h9999_999A})
            $display("FAIL cin_comb got %b_%h exp 0_9999999a", cout, z);
        else passed++;
    endtask

    task automatic test_reset_midstream();
        logic [WIDTH+1:0] e;
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({ovf_q, cout_q, z_q} !== {2'b01, 32'hFFFF_FFFE})
            $display("FAIL rst_preload got ovf=%b c=%b z=%h exp 0/1/fffffffe", ovf_q, cout_q, z_q);
        else passed++;
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({ovf_q, cout_q, z_q} !== {2'b00, 32'h0})
            $display("FAIL rst_clear got ovf=%b c=%b z=%h exp 0/0/00000000", ovf_q, cout_q, z_q);
        else passed++;
        total++;
        if ({cout, z} !== {1'b1, 32'hFFFF_FFFE})
            $display("FAIL rst_comb_kept got %b_%h exp 1_fffffffe", cout, z);
        else passed++;
        reset = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b1;
        e = model(a, b, cin);
        @(posedge clk); #1;
        total++;
        if ({ovf_q, cout_q, z_q} !== e)
            $display("FAIL rst_first_load got ovf=%b c=%b z=%h exp ovf=%b c=%b z=%h",
                     ovf_q, cout_q, z_q, e[WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_random_comb();
        test_carry_wrap();
        test_signed_overflow();
        test_carry_cin();
        test_reset_midstream();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_y_adder

`default_nettype wire

// File: doc/y_adder.md
Y_ADDER -- requirements
Module: y_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and sum width in bits.
REQ-002 Port clk, input, 1 bit: the single clock; all sequential logic SHALL be clocked on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port z, output, WIDTH bits: combinational sum a + b + cin, modulo 2^WIDTH.
REQ-005 Port cout, output, 1 bit: combinational carry out of bit WIDTH-1.
REQ-006 Port a, input, WIDTH bits: operand A, unsigned.
REQ-007 Port b, input, WIDTH bits: operand B, unsigned.
REQ-008 Port cin, input, 1 bit: carry into bit 0.
REQ-009 Port z_q, output, WIDTH bits: z registered on clk.
REQ-010 Port cout_q, output, 1 bit: cout registered on clk.
REQ-011 Port ovf_q, output, 1 bit: registered two's-complement overflow flag.
REQ-012 Port order for instantiation SHALL be: z, cout, a, b, cin, clk, reset, z_q, cout_q, ovf_q.
REQ-013 The leading five ports SHALL be positionally compatible with existing instantiations that connect only z, cout, a, b, cin; the remaining inputs are then unconnected.

Function
REQ-014 {cout, z} SHALL equal a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
REQ-015 z and cout SHALL be purely combinational, with zero clock latency.
REQ-016 z and cout SHALL settle within 1 time unit of any input change in simulation; there are no explicit delays.
REQ-017 z and cout SHALL be independent of clk and reset.
REQ-018 The sum SHALL be ripple-carry: bit i's carry-in SHALL be bit i-1's carry-out, and bit 0's carry-in SHALL be cin.
REQ-019 Overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-020 On each rising clk edge with reset low, z_q, cout_q and ovf_q SHALL load z, cout and overflow; latency is 1 cycle.
REQ-021 Wrap-around: all-ones + 0 + cin=1 SHALL give z=0 and cout=1.
REQ-022 Outputs SHALL never be X or Z when all inputs are 0/1.

Reset
REQ-023 When reset is high at a rising clk edge, z_q, cout_q and ovf_q SHALL become 0.
REQ-024 Reset SHALL take priority over loading the registers.
REQ-025 Reset SHALL NOT affect z or cout.
REQ-026 Asserting reset mid-stream SHALL clear the registers on that same edge; the first load after deassertion SHALL reflect the inputs present at that edge.

Structure
REQ-027 A shared package SHALL hold the default WIDTH constant (32); no typedefs are required.
REQ-028 One sub-module, y_adder1 (1-bit full adder: z, cout, a, b, cin), SHALL be instantiated WIDTH times in a generate loop.
REQ-029 In y_adder1, z SHALL be a^b^cin and cout SHALL be (a&b)|(cin&(a^b)).
REQ-030 The output registers SHALL live in y_adder itself.

Verification
REQ-031 Random: 500 iterations with random a and b and cin=0; after 1 time unit, z SHALL equal the expected a+b, with mismatches reported and zero failures required.
REQ-032 Carry wrap: a=32'hFFFFFFFF, b=0, cin=1 -> z=0, cout=1, overflow=0.
REQ-033 Signed overflow: a=32'h7FFFFFFF, b=1, cin=0 -> z=32'h80000000, cout=0, ovf_q=1 after one clk edge.
REQ-034 Carry with cin: a=32'h12345678, b=32'h87654321, cin=1 -> z=32'h9999999A, cout=0.
REQ-035 Reset: load a=b=32'hFFFFFFFF, then assert reset for one edge -> z_q=0, cout_q=0, ovf_q=0, while z=32'hFFFFFFFE and cout=1 remain.
REQ-036 Compatibility: instantiate with only the first five ports connected -> z and cout behave per REQ-014.
